// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock.
// Optional macro SIGNED_MULT_EN selects two's-complement operands.
module seq_shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 busy_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    res_q;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    final_val;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic             accept;
    logic             last_step;

    assign accept    = valid_i && (state_q == IDLE);
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SIGNED_MULT_EN
    logic sign_q;

    // Magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
    assign a_op      = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_op      = b_i[WIDTH-1] ? -b_i : b_i;
    assign final_val = sign_q ? -acc_sum : acc_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
        end
    end
`else
    assign a_op      = a_i;
    assign b_op      = b_i;
    assign final_val = acc_sum;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_i)   state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (ready_i)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else if (accept) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_op};
            mplier_q <= b_op;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == BUSY) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            // Only the final step publishes; no partial product is visible.
            if (last_step) begin
                res_q <= final_val;
            end
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q == BUSY);
    assign valid_o  = (state_q == DONE);
    assign result_o = res_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed-vector bench for seq_shift_add_mult (WIDTH = 32).
// Build with +define+SIGNED_MULT_EN to cover the signed variant.
module tb_seq_shift_add_mult;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] result_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    seq_shift_add_mult #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        while (!ready_o && g < 100) begin
            tick();
            g++;
        end
        chk("acc_ready", 64'(ready_o), 64'd1);
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("acc_busy", 64'(busy_o), 64'd1);
    endtask

    task automatic wait_done(input string tag, input logic [63:0] exp);
        lat = 0;
        while (!valid_o && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd32);
        chk({tag, "_res"}, result_o, exp);
    endtask

    task automatic consume();
        ready_i = 1'b1;
        tick();
        chk("cons_valid", 64'(valid_o), 64'd0);
        chk("cons_ready", 64'(ready_o), 64'd1);
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #12;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_res", result_o, 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Maximum operands, consumer always ready
        ready_i = 1'b1;
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef SIGNED_MULT_EN
        wait_done("max", 64'd1);
`else
        wait_done("max", 64'hFFFF_FFFE_0000_0001);
`endif
        tick();
        chk("max_valid_fall", 64'(valid_o), 64'd0);
        chk("max_ready_rise", 64'(ready_o), 64'd1);

        // Zero operand then back-to-back with valid_i held high
        a_i     = 32'd0;
        b_i     = 32'h1234_5678;
        valid_i = 1'b1;
        tick();
        a_i = 32'd7;
        b_i = 32'd6;
        chk("b2b_busy", 64'(busy_o), 64'd1);
        chk("b2b_nready", 64'(ready_o), 64'd0);
        wait_done("zero", 64'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!valid_o && lat < 100);
        valid_i = 1'b0;
        chk("b2b_gap", 64'(lat), 64'd34);
        chk("b2b_res", result_o, 64'd42);
        tick();
        tick();
        chk("b2b_idle", 64'(ready_o), 64'd1);

        // Back-pressure holds DONE
        ready_i = 1'b0;
        accept(32'd3, 32'd5);
        wait_done("bp", 64'd15);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_res", result_o, 64'd15);
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_ready", 64'(ready_o), 64'd0);
        end
        consume();

        // Asynchronous reset in the middle of BUSY
        ready_i = 1'b0;
        accept(32'd9, 32'd9);
        repeat (10) tick();
        chk("mid_busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("ar_valid", 64'(valid_o), 64'd0);
        chk("ar_res", result_o, 64'd0);
        chk("ar_ready", 64'(ready_o), 64'd1);
        chk("ar_busy", 64'(busy_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        accept(32'd2, 32'd3);
        wait_done("post_rst", 64'd6);
        consume();

        ready_i = 1'b0;
        accept(32'hFFFF_FFFD, 32'd7);
`ifdef SIGNED_MULT_EN
        wait_done("neg3x7", 64'hFFFF_FFFF_FFFF_FFEB);
`else
        wait_done("neg3x7", 64'h0000_0006_FFFF_FFEB);
`endif
        consume();
        ready_i = 1'b0;
        accept(32'h8000_0000, 32'h8000_0000);
        wait_done("minsq", 64'h4000_0000_0000_0000);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
